// File: rtl/striping_nlane.sv
// Round-robin striper: one word per clk_2f onto NUM_LANES lanes, per-word or whole-group release.
// Latency 1 cycle from accepting edge to lane outputs; no backpressure, every valid word is taken.
module striping_nlane #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = 2,
  parameter int ALIGNED    = 0,
  localparam int PTR_W     = (NUM_LANES > 2) ? $clog2(NUM_LANES) : 1
) (
  input  logic                            clk_2f,
  input  logic                            reset,
  input  logic                            valid_in,
  input  logic [DATA_WIDTH-1:0]           data_in,
  output logic [NUM_LANES*DATA_WIDTH-1:0] lane_data,
  output logic [NUM_LANES-1:0]            lane_valid,
  output logic [PTR_W-1:0]                lane_ptr,
  output logic                            group_done
);

  logic [PTR_W-1:0] ptr;
  logic             last;

  assign last     = (ptr == PTR_W'(NUM_LANES - 1));
  assign lane_ptr = ptr;

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (valid_in) begin
      ptr <= last ? '0 : ptr + 1'b1;
    end
  end

  if (ALIGNED != 0) begin : g_aligned
    // One slot per lane so the index width matches ptr; the top slot is never staged,
    // the final word of a group is taken straight from data_in.
    logic [DATA_WIDTH-1:0] staging [NUM_LANES];

    always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
        lane_data  <= '0;
        lane_valid <= '0;
        group_done <= 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
          staging[k] <= '0;
        end
      end else begin
        lane_valid <= '0;
        group_done <= 1'b0;
        if (valid_in) begin
          if (last) begin
            for (int k = 0; k < NUM_LANES - 1; k++) begin
              lane_data[k*DATA_WIDTH +: DATA_WIDTH] <= staging[k];
            end
            lane_data[(NUM_LANES-1)*DATA_WIDTH +: DATA_WIDTH] <= data_in;
            lane_valid <= '1;
            group_done <= 1'b1;
          end else begin
            staging[ptr] <= data_in;
          end
        end
      end
    end
  end else begin : g_per_word
    always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
        lane_data  <= '0;
        lane_valid <= '0;
        group_done <= 1'b0;
      end else begin
        lane_valid <= '0;
        group_done <= 1'b0;
        if (valid_in) begin
          lane_data[ptr*DATA_WIDTH +: DATA_WIDTH] <= data_in;
          lane_valid[ptr] <= 1'b1;
          group_done      <= last;
        end
      end
    end
  end

endmodule

// File: tb/tb_striping_nlane.sv
// Bench for striping_nlane: three instances (N=2 per-word, N=3 per-word, N=4 aligned)
// compared every cycle against a word-count reference model.
module tb_striping_nlane;

  logic        clk_2f = 1'b0;
  logic        reset  = 1'b0;
  logic        v_in [3];
  logic [31:0] d_in [3];

  logic [63:0]  ld0;
  logic [1:0]   lv0;
  logic [0:0]   lp0;
  logic         gd0;
  logic [95:0]  ld1;
  logic [2:0]   lv1;
  logic [1:0]   lp1;
  logic         gd1;
  logic [127:0] ld2;
  logic [3:0]   lv2;
  logic [1:0]   lp2;
  logic         gd2;

  always #5 clk_2f = ~clk_2f;

  striping_nlane #(.DATA_WIDTH(32), .NUM_LANES(2), .ALIGNED(0)) u_n2 (
    .clk_2f(clk_2f), .reset(reset), .valid_in(v_in[0]), .data_in(d_in[0]),
    .lane_data(ld0), .lane_valid(lv0), .lane_ptr(lp0), .group_done(gd0));

  striping_nlane #(.DATA_WIDTH(32), .NUM_LANES(3), .ALIGNED(0)) u_n3 (
    .clk_2f(clk_2f), .reset(reset), .valid_in(v_in[1]), .data_in(d_in[1]),
    .lane_data(ld1), .lane_valid(lv1), .lane_ptr(lp1), .group_done(gd1));

  striping_nlane #(.DATA_WIDTH(32), .NUM_LANES(4), .ALIGNED(1)) u_n4a (
    .clk_2f(clk_2f), .reset(reset), .valid_in(v_in[2]), .data_in(d_in[2]),
    .lane_data(ld2), .lane_valid(lv2), .lane_ptr(lp2), .group_done(gd2));

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: lane of a word = (words accepted since reset) mod N.
  int          nl  [3] = '{2, 3, 4};
  bit          al  [3] = '{1'b0, 1'b0, 1'b1};
  int          cnt [3];
  logic [31:0] mdata  [3][4];
  logic [31:0] mstage [3][4];
  logic [3:0]  mvld [3];
  bit          mgd  [3];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0; mvld[i] = '0; mgd[i] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        mdata[i][k] = '0; mstage[i][k] = '0;
      end
    end
  endtask

  task automatic model_step(input int id);
    int lane;
    mvld[id] = '0;
    mgd[id]  = 1'b0;
    if (v_in[id]) begin
      lane = cnt[id] % nl[id];
      cnt[id]++;
      if (!al[id]) begin
        mdata[id][lane] = d_in[id];
        mvld[id][lane]  = 1'b1;
        mgd[id]         = (lane == nl[id] - 1);
      end else begin
        mstage[id][lane] = d_in[id];
        if (lane == nl[id] - 1) begin
          for (int k = 0; k < nl[id]; k++) mdata[id][k] = mstage[id][k];
          mvld[id] = 4'((1 << nl[id]) - 1);
          mgd[id]  = 1'b1;
        end
      end
    end
  endtask

  task automatic check_dut(input int id);
    logic [127:0] exp_d;
    logic [127:0] od;
    logic [3:0]   ov;
    logic [1:0]   op;
    logic         og;
    exp_d = '0;
    for (int k = 0; k < nl[id]; k++) exp_d[k*32 +: 32] = mdata[id][k];
    case (id)
      0:       begin od = 128'(ld0); ov = 4'(lv0); op = 2'(lp0); og = gd0; end
      1:       begin od = 128'(ld1); ov = 4'(lv1); op = lp1;      og = gd1; end
      default: begin od = ld2;       ov = lv2;     op = lp2;      og = gd2; end
    endcase
    chk($sformatf("d%0d lane_data", id),  od, exp_d);
    chk($sformatf("d%0d lane_valid", id), 128'(ov), 128'(mvld[id]));
    chk($sformatf("d%0d lane_ptr", id),   128'(op), 128'(cnt[id] % nl[id]));
    chk($sformatf("d%0d group_done", id), 128'(og), 128'(mgd[id]));
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) check_dut(i);
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) begin
      v_in[i] = 1'b0; d_in[i] = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk_2f);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    check_all();
  endtask

  logic [31:0] t1_dat [4] = '{32'hFFFFFFFF, 32'hEEEEEEEE, 32'hDDDDDDDD, 32'hCCCCCCCC};
  logic [1:0]  t1_vld [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [31:0] sb_q [$];

  initial begin
    idle();
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk_2f);
    #2 reset = 1'b1;

    // Per-word, N=2: four back-to-back words.
    for (int i = 0; i < 4; i++) begin
      v_in[0] = 1'b1; d_in[0] = t1_dat[i];
      tick();
      chk("t1 lane_valid", 128'(lv0), 128'(t1_vld[i]));
      chk("t1 group_done", 128'(gd0), 128'(i % 2));
    end
    chk("t1 final lanes", 128'(ld0), 128'({32'hCCCCCCCC, 32'hDDDDDDDD}));

    // Gap hold: pointer and data hold while valid_in is low.
    v_in[0] = 1'b1; d_in[0] = 32'hBBBBBBBB; tick();
    for (int i = 1; i <= 2; i++) begin
      v_in[0] = 1'b0; d_in[0] = 32'(i); tick();
      chk("t2 gap ptr", 128'(lp0), 128'(1));
      chk("t2 gap valid", 128'(lv0), 128'(0));
    end
    v_in[0] = 1'b1; d_in[0] = 32'd3; tick();
    v_in[0] = 1'b1; d_in[0] = 32'd4; tick();
    chk("t2 lanes", 128'(ld0), 128'({32'd3, 32'd4}));
    idle();

    // N=3 round-robin with 1..7.
    for (int i = 1; i <= 7; i++) begin
      v_in[1] = 1'b1; d_in[1] = 32'(i); tick();
      chk("t3 lane_valid", 128'(lv1), 128'(1 << ((i - 1) % 3)));
    end
    idle();
    tick();

    // Aligned N=4 with a gap after the second word.
    v_in[2] = 1'b1; d_in[2] = 32'hA0A0A0A0; tick();
    v_in[2] = 1'b1; d_in[2] = 32'hA1A1A1A1; tick();
    v_in[2] = 1'b0; tick();
    v_in[2] = 1'b1; d_in[2] = 32'hA2A2A2A2; tick();
    chk("t4 no early release", 128'(lv2), 128'(0));
    v_in[2] = 1'b1; d_in[2] = 32'hA3A3A3A3; tick();
    chk("t4 release valid", 128'(lv2), 128'(4'b1111));
    chk("t4 release data", ld2, {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0});
    idle(); tick();
    chk("t4 after release", 128'(lv2), 128'(0));

    // Asynchronous reset in the middle of an aligned group.
    v_in[2] = 1'b1; d_in[2] = 32'h00000A00; tick();
    v_in[2] = 1'b1; d_in[2] = 32'h00000A01; tick();
    idle();
    reset = 1'b0;
    #1;
    chk("t5 async data", ld2, 128'(0));
    chk("t5 async ptr", 128'(lp2), 128'(0));
    model_reset();
    check_all();
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v_in[2] = 1'b1; d_in[2] = 32'hB0 + 32'(i); tick();
    end
    chk("t5 release", ld2, {32'hB3, 32'hB2, 32'hB1, 32'hB0});

    // Random traffic on all three instances.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 3; i++) begin
        v_in[i] = ($urandom_range(0, 3) != 0);
        d_in[i] = $urandom;
      end
      tick();
    end
    idle();

    // Continuous stream on N=2 checked by an in-order scoreboard.
    begin
      int exp_lane;
      int lane;
      exp_lane = cnt[0] % 2;
      for (int c = 0; c < 100; c++) begin
        v_in[0] = 1'b1; d_in[0] = $urandom;
        sb_q.push_back(d_in[0]);
        tick();
        lane = (lv0 == 2'b10) ? 1 : 0;
        chk("t6 lane", 128'(lane), 128'(exp_lane));
        if (sb_q.size() > 0) chk("t6 word", 128'(ld0[lane*32 +: 32]), 128'(sb_q.pop_front()));
        exp_lane ^= 1;
      end
    end
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
